// File: rtl/cpu_io_dispatch.sv
// Z80 I/O port dispatcher: synchronises CPU I/O strobes, decodes A[7:2] onto NUM_CH peripheral channels.
// Optional handshake mode with per-channel ack and timeout is enabled by defining CPU_IO_ACK_EN.
module cpu_io_dispatch #(
  parameter int unsigned                NUM_CH      = 4,
  parameter int unsigned                ADDR_W      = 6,
  parameter int unsigned                SYNC_STAGES = 2,
  parameter logic [NUM_CH*ADDR_W-1:0]   BASE_ADDRS  = {6'h2A, 6'h29, 6'h28, 6'h26},
  parameter int unsigned                READ_LAT    = 1,
  parameter int unsigned                ACK_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     A,
  input  logic                  rd_iorq_n,
  input  logic                  wr_iorq_n,
  input  logic [7:0]            cd_in,
  output logic [7:0]            cd_out,
  output logic                  cd_oe,
  output logic                  cs_n,
  output logic [NUM_CH-1:0]     io_req,
  output logic                  io_wr,
  output logic [7:0]            io_data_out,
  input  logic [NUM_CH*8-1:0]   io_data_in,
  input  logic [NUM_CH-1:0]     io_ack,
  output logic                  timeout_err
);

  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CNT_MAX = (READ_LAT > ACK_TIMEOUT) ? READ_LAT : ACK_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

`ifdef CPU_IO_ACK_EN
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2, WAIT_ACK = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2} state_t;
`endif

  state_t state_q, state_d;

  // Strobe synchronisers plus one extra flop for falling-edge detection
  logic [SYNC_STAGES-1:0] rd_sync, wr_sync;
  logic rd_s, wr_s, rd_prev, wr_prev, rd_fall, wr_fall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_sync <= '1;
      wr_sync <= '1;
      rd_prev <= 1'b1;
      wr_prev <= 1'b1;
    end else begin
      rd_sync <= {rd_sync[SYNC_STAGES-2:0], rd_iorq_n};
      wr_sync <= {wr_sync[SYNC_STAGES-2:0], wr_iorq_n};
      rd_prev <= rd_s;
      wr_prev <= wr_s;
    end
  end

  assign rd_s    = rd_sync[SYNC_STAGES-1];
  assign wr_s    = wr_sync[SYNC_STAGES-1];
  assign rd_fall = rd_prev & ~rd_s;
  assign wr_fall = wr_prev & ~wr_s;

  // Address decode: descending scan so the lowest matching channel wins
  logic            dec_hit;
  logic [CH_W-1:0] dec_ch;

  always_comb begin
    dec_hit = 1'b0;
    dec_ch  = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (A == BASE_ADDRS[i*ADDR_W +: ADDR_W]) begin
        dec_hit = 1'b1;
        dec_ch  = CH_W'(i);
      end
    end
  end

  // Per-access context
  logic [CH_W-1:0]  ch_q, ch_d;
  logic             rd_acc_q, rd_acc_d;
  logic             hit_q, hit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       rd_byte;

  assign rd_byte = io_data_in[{ch_q, 3'b000} +: 8];

  logic [7:0]        cd_out_d, io_data_out_d;
  logic              cd_oe_d, cs_n_d, io_wr_d, timeout_d;
  logic [NUM_CH-1:0] io_req_d;

`ifndef CPU_IO_ACK_EN
  logic unused_ack;
  assign unused_ack = ^io_ack;
`endif

  always_comb begin
    state_d       = state_q;
    ch_d          = ch_q;
    rd_acc_d      = rd_acc_q;
    hit_d         = hit_q;
    cnt_d         = cnt_q;
    cd_out_d      = cd_out;
    cd_oe_d       = cd_oe;
    cs_n_d        = cs_n;
    io_req_d      = io_req;
    io_wr_d       = io_wr;
    io_data_out_d = io_data_out;
    timeout_d     = timeout_err;

    case (state_q)
      IDLE: begin
        cs_n_d   = 1'b1;
        cd_oe_d  = 1'b0;
        io_req_d = '0;
        if (rd_fall || wr_fall) begin
          state_d = HOLD;
          hit_d   = 1'b0;
          // Both strobes low is an invalid cycle: park in HOLD untouched
          if (!(~rd_s && ~wr_s) && dec_hit) begin
            state_d  = REQ;
            hit_d    = 1'b1;
            ch_d     = dec_ch;
            rd_acc_d = ~rd_s;
            cnt_d    = '0;
            cs_n_d   = 1'b0;
            io_req_d = NUM_CH'(1) << dec_ch;
            io_wr_d  = ~wr_s;
            if (~wr_s) io_data_out_d = cd_in;
          end
        end
      end

`ifdef CPU_IO_ACK_EN
      REQ, WAIT_ACK: begin
        if (io_ack[ch_q]) begin
          io_req_d = '0;
          if (rd_acc_q) cd_out_d = rd_byte;
          state_d = HOLD;
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          io_req_d  = '0;
          cd_out_d  = 8'hFF;
          timeout_d = 1'b1;
          state_d   = HOLD;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = WAIT_ACK;
        end
      end
`else
      REQ: begin
        io_req_d = '0;
        if (!rd_acc_q) begin
          state_d = HOLD;
        end else if (cnt_q == CNT_W'(READ_LAT - 1)) begin
          cd_out_d = rd_byte;
          state_d  = HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif

      HOLD: begin
        cd_oe_d = hit_q & rd_acc_q & ~rd_s;
        if (rd_s && wr_s) begin
          state_d = IDLE;
          cs_n_d  = 1'b1;
          cd_oe_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      rd_acc_q    <= 1'b0;
      hit_q       <= 1'b0;
      cnt_q       <= '0;
      cd_out      <= '0;
      cd_oe       <= 1'b0;
      cs_n        <= 1'b1;
      io_req      <= '0;
      io_wr       <= 1'b0;
      io_data_out <= '0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      rd_acc_q    <= rd_acc_d;
      hit_q       <= hit_d;
      cnt_q       <= cnt_d;
      cd_out      <= cd_out_d;
      cd_oe       <= cd_oe_d;
      cs_n        <= cs_n_d;
      io_req      <= io_req_d;
      io_wr       <= io_wr_d;
      io_data_out <= io_data_out_d;
      timeout_err <= timeout_d;
    end
  end

endmodule

// File: tb/tb_cpu_io_dispatch.sv
// Scoreboard bench for cpu_io_dispatch; ack-mode scenarios are included when CPU_IO_ACK_EN is defined.
module tb_cpu_io_dispatch;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  A;
  logic        rd_iorq_n, wr_iorq_n;
  logic [7:0]  cd_in, cd_out, io_data_out;
  logic        cd_oe, cs_n, io_wr, timeout_err;
  logic [3:0]  io_req, io_ack;
  logic [31:0] io_data_in;

  cpu_io_dispatch dut (
    .clk(clk), .reset(reset), .A(A), .rd_iorq_n(rd_iorq_n), .wr_iorq_n(wr_iorq_n),
    .cd_in(cd_in), .cd_out(cd_out), .cd_oe(cd_oe), .cs_n(cs_n), .io_req(io_req),
    .io_wr(io_wr), .io_data_out(io_data_out), .io_data_in(io_data_in), .io_ack(io_ack),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] onehot;
    logic       wr;
    logic [7:0] data;
  } req_t;

  req_t       req_q[$];
  logic [7:0] rd_q[$];

  int checks = 0;
  int errors = 0;
  int exp_req_width = 1;
  int exp_oe_lat = 2;
  bit expect_timeout = 1'b0;
  bit ack_auto = 1'b1;
  logic [3:0] ack_fixed = 4'b0000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int decode(input logic [5:0] a);
    logic [5:0] bases [4];
    bases = '{6'h26, 6'h28, 6'h29, 6'h2A};
    for (int i = 0; i < 4; i++) if (a == bases[i]) return i;
    return -1;
  endfunction

  // Peripheral model: acks whatever is requested, or drives a fixed ack pattern
  initial begin
    io_ack = 4'b0000;
    forever begin
      @(negedge clk);
      io_ack = ack_auto ? io_req : ack_fixed;
    end
  end

  // Monitor: pops expected requests on io_req rise and expected read data on cd_oe rise
  int cyc = 0;
  int req_rise_cyc = 0;
  int req_w = 0;
  logic [3:0] prev_req = 4'b0000;
  logic prev_oe = 1'b0;

  always @(negedge clk) begin
    req_t e;
    logic [7:0] d;
    cyc++;
    if (!reset) begin
      if (io_req != 4'b0000 && prev_req == 4'b0000) begin
        req_rise_cyc = cyc;
        req_w = 1;
        if (req_q.size() == 0) check("req_unexpected", 32'(io_req), 32'd0);
        else begin
          e = req_q.pop_front();
          check("req_onehot", 32'(io_req), 32'(e.onehot));
          check("req_wr", 32'(io_wr), 32'(e.wr));
          if (e.wr) check("req_data", 32'(io_data_out), 32'(e.data));
        end
      end else if (io_req != 4'b0000) begin
        req_w++;
      end else if (prev_req != 4'b0000) begin
        check("req_width", 32'(req_w), 32'(exp_req_width));
      end
      if (cd_oe && !prev_oe) begin
        check("oe_latency", 32'(cyc - req_rise_cyc), 32'(exp_oe_lat));
        if (rd_q.size() == 0) check("oe_unexpected", 32'(cd_oe), 32'd0);
        else begin
          d = rd_q.pop_front();
          check("rd_data", 32'(cd_out), 32'(d));
        end
      end
    end
    prev_req = io_req;
    prev_oe  = cd_oe;
  end

  // One CPU I/O cycle with strobes held low for 'hold' cycles (hold >= 6)
  task automatic access(input logic [5:0] addr, input bit do_rd, input bit do_wr,
                        input logic [7:0] data, input int hold);
    int   ch;
    bit   hit, rd_hit, oe_bad;
    logic [3:0] exp_oh;
    req_t e;
    ch     = decode(addr);
    hit    = !(do_rd && do_wr) && (do_rd || do_wr) && (ch >= 0);
    rd_hit = hit && do_rd;
    exp_oh = hit ? 4'(1 << ch) : 4'b0000;
    oe_bad = 1'b0;
    if (hit) begin
      e.onehot = exp_oh;
      e.wr     = do_wr;
      e.data   = data;
      req_q.push_back(e);
    end
    if (rd_hit) rd_q.push_back(expect_timeout ? 8'hFF : io_data_in[ch*8 +: 8]);
    A = addr;
    cd_in = data;
    rd_iorq_n = !do_rd;
    wr_iorq_n = !do_wr;
    for (int i = 1; i <= hold; i++) begin
      @(negedge clk);
      if (i == 2) check("req_early", 32'(io_req), 32'd0);
      if (i == 3) begin
        check("req_sel", 32'(io_req), 32'(exp_oh));
        check("cs_n_active", 32'(cs_n), 32'(!hit));
      end
      if (cd_oe && !rd_hit) oe_bad = 1'b1;
    end
    check("oe_hold", 32'(cd_oe), 32'(rd_hit));
    rd_iorq_n = 1'b1;
    wr_iorq_n = 1'b1;
    repeat (2) @(negedge clk);
    check("oe_tail", 32'(cd_oe), 32'(rd_hit));
    @(negedge clk);
    check("oe_off", 32'(cd_oe), 32'd0);
    check("cs_n_idle", 32'(cs_n), 32'd1);
    check("oe_spurious", 32'(oe_bad), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    req_t e;
    reset = 1'b1;
    A = '0;
    cd_in = '0;
    rd_iorq_n = 1'b1;
    wr_iorq_n = 1'b1;
    io_data_in = {8'h44, 8'h33, 8'hC3, 8'h11};
`ifdef CPU_IO_ACK_EN
    exp_req_width = 2;
`endif
    #1;
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_cd_oe", 32'(cd_oe), 32'd0);
    check("rst_cd_out", 32'(cd_out), 32'd0);
    check("rst_io_req", 32'(io_req), 32'd0);
    check("rst_io_wr", 32'(io_wr), 32'd0);
    check("rst_io_data_out", 32'(io_data_out), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    access(6'h26, 1'b0, 1'b1, 8'h5A, 6);   // write ch0
    access(6'h28, 1'b1, 1'b0, 8'h00, 6);   // read ch1
    access(6'h3F, 1'b1, 1'b0, 8'h00, 6);   // unmapped read
    access(6'h26, 1'b1, 1'b1, 8'hAA, 6);   // invalid: both strobes low
    access(6'h26, 1'b0, 1'b1, 8'h3C, 6);   // next valid write
    access(6'h29, 1'b0, 1'b1, 8'h81, 6);   // write ch2
    access(6'h2A, 1'b1, 1'b0, 8'h00, 7);   // read ch3 (top base)
    access(6'h27, 1'b1, 1'b0, 8'h00, 6);   // between bases: no hit
    access(6'h25, 1'b0, 1'b1, 8'h11, 6);   // just below ch0: no hit
    io_data_in[7:0] = 8'hE7;
    access(6'h26, 1'b1, 1'b0, 8'h00, 6);   // read ch0 with new data

    // Strobe released after one cycle: request still issued, access completes
    e.onehot = 4'b1000; e.wr = 1'b1; e.data = 8'h77;
    req_q.push_back(e);
    A = 6'h2A; cd_in = 8'h77; wr_iorq_n = 1'b0;
    @(negedge clk);
    wr_iorq_n = 1'b1;
    repeat (6) @(negedge clk);
    check("early_cs_n", 32'(cs_n), 32'd1);
    check("early_req_done", 32'(req_q.size()), 32'd0);

    // Async reset while io_req is high
    e.onehot = 4'b0100; e.wr = 1'b0; e.data = 8'h00;
    req_q.push_back(e);
    A = 6'h29; rd_iorq_n = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_req", 32'(io_req), 32'h4);
    #2 reset = 1'b1;
    #1;
    check("async_rst_req", 32'(io_req), 32'd0);
    check("async_rst_cs_n", 32'(cs_n), 32'd1);
    check("async_rst_oe", 32'(cd_oe), 32'd0);
    rd_iorq_n = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Async reset while cd_oe is driving the bus
    e.onehot = 4'b1000; e.wr = 1'b0; e.data = 8'h00;
    req_q.push_back(e);
    rd_q.push_back(8'h44);
    A = 6'h2A; rd_iorq_n = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_rst_oe", 32'(cd_oe), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_oe2", 32'(cd_oe), 32'd0);
    check("async_rst_cd_out", 32'(cd_out), 32'd0);
    rd_iorq_n = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    access(6'h28, 1'b0, 1'b1, 8'hC5, 6);   // first access after reset

`ifdef CPU_IO_ACK_EN
    // No ack on the selected channel; other channels ack and must be ignored
    ack_auto = 1'b0;
    ack_fixed = 4'b1011;
    expect_timeout = 1'b1;
    exp_req_width = 16;
    exp_oe_lat = 17;
    access(6'h29, 1'b1, 1'b0, 8'h00, 24);
    check("timeout_set", 32'(timeout_err), 32'd1);
    ack_auto = 1'b1;
    expect_timeout = 1'b0;
    exp_req_width = 2;
    exp_oe_lat = 2;
    access(6'h28, 1'b1, 1'b0, 8'h00, 6);
    check("timeout_sticky", 32'(timeout_err), 32'd1);
    reset = 1'b1;
    #1;
    check("timeout_cleared", 32'(timeout_err), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
`endif

    check("req_queue_empty", 32'(req_q.size()), 32'd0);
    check("rd_queue_empty", 32'(rd_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
